// File: rtl/ingreso_monto_pkg.sv
// Shared key codes, FSM state encoding and accumulator opcodes for the amount-entry
// keypad front end. Kept in one package so the cajero side and its tester agree on them.
package ingreso_monto_pkg;

  localparam int unsigned ANCHO_MONTO = 32;
  localparam int unsigned ANCHO_TECLA = 4;
  localparam int unsigned ANCHO_CNT   = 4;

  localparam logic [ANCHO_TECLA-1:0] TECLA_ENTER    = ANCHO_TECLA'(4'hA);
  localparam logic [ANCHO_TECLA-1:0] TECLA_CANCELAR = ANCHO_TECLA'(4'hB);
  localparam logic [ANCHO_TECLA-1:0] TECLA_BORRAR   = ANCHO_TECLA'(4'hC);

  typedef enum logic [1:0] {
    ESPERA  = 2'd0,
    CAPTURA = 2'd1,
    ENTREGA = 2'd2
  } estado_t;

  typedef enum logic [1:0] {
    OP_NADA    = 2'd0,
    OP_LIMPIAR = 2'd1,
    OP_DIGITO  = 2'd2,
    OP_BORRAR  = 2'd3
  } acc_op_t;

  function automatic logic es_digito(input logic [ANCHO_TECLA-1:0] t);
    return t <= ANCHO_TECLA'(9);
  endfunction

endpackage

// File: rtl/ingreso_monto_acumulador_decimal.sv
// Decimal accumulator: holds the partial amount and its digit count.
// The /10 path exists only when INGRESO_MONTO_BORRAR_EN is defined.
module acumulador_decimal
  import ingreso_monto_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             op,
  input  logic [ANCHO_TECLA-1:0] digito,
  output logic [ANCHO_MONTO-1:0] acc,
  output logic [ANCHO_CNT-1:0]   digitos_cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      digitos_cnt <= '0;
    end else begin
      case (acc_op_t'(op))
        OP_LIMPIAR: begin
          acc         <= '0;
          digitos_cnt <= '0;
        end
        OP_DIGITO: begin
          acc         <= acc * ANCHO_MONTO'(10) + ANCHO_MONTO'(digito);
          digitos_cnt <= digitos_cnt + ANCHO_CNT'(1);
        end
`ifdef INGRESO_MONTO_BORRAR_EN
        OP_BORRAR: begin
          acc         <= acc / ANCHO_MONTO'(10);
          digitos_cnt <= digitos_cnt - ANCHO_CNT'(1);
        end
`endif
        default: begin
          acc         <= acc;
          digitos_cnt <= digitos_cnt;
        end
      endcase
    end
  end

endmodule

// File: rtl/ingreso_monto.sv
// Keypad amount entry: assembles decimal digits into a binary amount for the cajero.
// Optional BORRAR (backspace) key is enabled by defining INGRESO_MONTO_BORRAR_EN.
module ingreso_monto
  import ingreso_monto_pkg::*;
#(
  parameter int unsigned MAX_DIGITOS = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   habilitar,
  input  logic [ANCHO_TECLA-1:0] tecla,
  input  logic                   tecla_stb,
  output logic [ANCHO_MONTO-1:0] monto,
  output logic                   monto_stb,
  output logic [ANCHO_CNT-1:0]   digitos_cnt,
  output logic                   error_entrada,
  output logic                   capturando
);

  estado_t                state, state_next;
  acc_op_t                op;
  logic                   cargar, stb_next, err_next, lleno;
  logic [ANCHO_MONTO-1:0] acc;

  acumulador_decimal u_acc (
    .clk         (clk),
    .rst         (rst),
    .op          (op),
    .digito      (tecla),
    .acc         (acc),
    .digitos_cnt (digitos_cnt)
  );

  assign lleno = (digitos_cnt == ANCHO_CNT'(MAX_DIGITOS));

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ESPERA;
      capturando    <= 1'b0;
      monto         <= '0;
      monto_stb     <= 1'b0;
      error_entrada <= 1'b0;
    end else begin
      state         <= state_next;
      capturando    <= (state_next == CAPTURA);
      if (cargar) monto <= acc;
      monto_stb     <= stb_next;
      error_entrada <= err_next;
    end
  end

  // habilitar dominates any coincident key; ENTREGA always flushes the accumulator.
  always_comb begin
    state_next = state;
    op         = OP_NADA;
    cargar     = 1'b0;
    stb_next   = 1'b0;
    err_next   = 1'b0;
    case (state)
      ESPERA: begin
        if (habilitar) begin
          state_next = CAPTURA;
          op         = OP_LIMPIAR;
        end
      end
      CAPTURA: begin
        if (!habilitar) begin
          state_next = ESPERA;
          op         = OP_LIMPIAR;
        end else if (tecla_stb) begin
          if (es_digito(tecla)) begin
            if (lleno) err_next = 1'b1;
            else       op       = OP_DIGITO;
          end else begin
            case (tecla)
              TECLA_ENTER: begin
                if (digitos_cnt != '0) begin
                  cargar     = 1'b1;
                  stb_next   = 1'b1;
                  state_next = ENTREGA;
                end else begin
                  err_next = 1'b1;
                end
              end
              TECLA_CANCELAR: op = OP_LIMPIAR;
`ifdef INGRESO_MONTO_BORRAR_EN
              TECLA_BORRAR: begin
                if (digitos_cnt != '0) op       = OP_BORRAR;
                else                   err_next = 1'b1;
              end
`endif
              default: err_next = 1'b1;
            endcase
          end
        end
      end
      ENTREGA: begin
        op         = OP_LIMPIAR;
        state_next = habilitar ? CAPTURA : ESPERA;
      end
      default: state_next = ESPERA;
    endcase
  end

endmodule

// File: tb/tb_ingreso_monto.sv
// Self-checking bench for ingreso_monto: scoreboard of expected delivered amounts
// plus per-scenario inline checks of error pulses, digit count and state flag.
module tb_ingreso_monto;

  localparam logic [3:0] K_ENTER    = 4'hA;
  localparam logic [3:0] K_CANCELAR = 4'hB;
  localparam logic [3:0] K_BORRAR   = 4'hC;

  logic        clk = 1'b0;
  logic        rst;
  logic        habilitar;
  logic [3:0]  tecla;
  logic        tecla_stb;
  logic [31:0] monto;
  logic        monto_stb;
  logic [3:0]  digitos_cnt;
  logic        error_entrada;
  logic        capturando;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  ingreso_monto #(.MAX_DIGITOS(9)) dut (
    .clk           (clk),
    .rst           (rst),
    .habilitar     (habilitar),
    .tecla         (tecla),
    .tecla_stb     (tecla_stb),
    .monto         (monto),
    .monto_stb     (monto_stb),
    .digitos_cnt   (digitos_cnt),
    .error_entrada (error_entrada),
    .capturando    (capturando)
  );

  // Scoreboard: every strobe must match the oldest pending expected amount.
  always @(negedge clk) begin
    logic [31:0] e;
    if (monto_stb === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: monto=%0d with no delivery pending", monto);
      end else begin
        e = exp_q.pop_front();
        if (monto !== e) begin
          errors++;
          $display("FAIL scoreboard_monto: got %0d expected %0d", monto, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_key(input logic [3:0] k, output logic err_obs);
    @(negedge clk);
    tecla     = k;
    tecla_stb = 1'b1;
    @(negedge clk);
    tecla_stb = 1'b0;
    err_obs   = error_entrada;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_capt();
    for (int i = 0; i < 10 && capturando !== 1'b1; i++) @(negedge clk);
    checks++;
    if (capturando !== 1'b1) begin
      errors++;
      $display("FAIL wait_capturando: timeout, capturando=%b expected 1", capturando);
    end
  endtask

  task automatic test_reset();
    logic e;
    rst = 1'b1; habilitar = 1'b0; tecla = 4'h0; tecla_stb = 1'b0;
    idle(2);
    checks++;
    if ({monto, monto_stb, digitos_cnt, error_entrada, capturando} !== 39'd0) begin
      errors++;
      $display("FAIL reset_outputs: monto=%0d stb=%b cnt=%0d err=%b capt=%b expected all 0",
               monto, monto_stb, digitos_cnt, error_entrada, capturando);
    end
    rst = 1'b0;
    drive_key(4'h5, e);
    checks++;
    if (e !== 1'b0 || capturando !== 1'b0 || digitos_cnt !== 4'd0) begin
      errors++;
      $display("FAIL espera_key_ignored: err=%b capt=%b cnt=%0d expected 0 0 0", e, capturando, digitos_cnt);
    end
    habilitar = 1'b1;
    wait_capt();
  endtask

  task automatic test_basic();
    logic e;
    int nerr;
    logic [3:0] keys [4] = '{4'h1, 4'h2, 4'h5, 4'h0};
    nerr = 0;
    foreach (keys[i]) begin
      drive_key(keys[i], e);
      if (e !== 1'b0) nerr++;
    end
    checks++;
    if (nerr != 0 || digitos_cnt !== 4'd4) begin
      errors++;
      $display("FAIL basic_digits: errs=%0d cnt=%0d expected 0 and 4", nerr, digitos_cnt);
    end
    exp_q.push_back(32'd1250);
    drive_key(K_ENTER, e);
    checks++;
    if (e !== 1'b0 || monto_stb !== 1'b1 || monto !== 32'd1250) begin
      errors++;
      $display("FAIL basic_enter: err=%b stb=%b monto=%0d expected 0 1 1250", e, monto_stb, monto);
    end
    idle(1);
    checks++;
    if (monto_stb !== 1'b0 || digitos_cnt !== 4'd0 || capturando !== 1'b1) begin
      errors++;
      $display("FAIL basic_after: stb=%b cnt=%0d capt=%b expected 0 0 1", monto_stb, digitos_cnt, capturando);
    end
  endtask

  task automatic test_overflow();
    logic e;
    int nerr;
    nerr = 0;
    for (int i = 0; i < 9; i++) begin
      drive_key(4'h9, e);
      if (e !== 1'b0) nerr++;
    end
    checks++;
    if (nerr != 0 || digitos_cnt !== 4'd9) begin
      errors++;
      $display("FAIL overflow_fill: errs=%0d cnt=%0d expected 0 and 9", nerr, digitos_cnt);
    end
    drive_key(4'h7, e);
    checks++;
    if (e !== 1'b1) begin
      errors++;
      $display("FAIL overflow_err: err=%b expected 1", e);
    end
    idle(1);
    checks++;
    if (error_entrada !== 1'b0 || digitos_cnt !== 4'd9) begin
      errors++;
      $display("FAIL overflow_pulse: err=%b cnt=%0d expected 0 and 9", error_entrada, digitos_cnt);
    end
    exp_q.push_back(32'd999999999);
    drive_key(K_ENTER, e);
    idle(1);
  endtask

  task automatic test_empty_enter();
    logic e;
    drive_key(K_ENTER, e);
    checks++;
    if (e !== 1'b1 || monto_stb !== 1'b0 || monto !== 32'd999999999 || capturando !== 1'b1) begin
      errors++;
      $display("FAIL empty_enter: err=%b stb=%b monto=%0d capt=%b expected 1 0 999999999 1",
               e, monto_stb, monto, capturando);
    end
  endtask

  task automatic test_invalid_cancel();
    logic e1, e2, e3;
    drive_key(4'hD, e1);
    drive_key(4'hF, e2);
    checks++;
    if (e1 !== 1'b1 || e2 !== 1'b1) begin
      errors++;
      $display("FAIL invalid_keys: errD=%b errF=%b expected 1 1", e1, e2);
    end
    drive_key(4'h1, e1);
    drive_key(4'h2, e2);
    drive_key(K_CANCELAR, e3);
    checks++;
    if (e3 !== 1'b0 || digitos_cnt !== 4'd0) begin
      errors++;
      $display("FAIL cancelar: err=%b cnt=%0d expected 0 0", e3, digitos_cnt);
    end
    drive_key(4'h4, e1);
    exp_q.push_back(32'd4);
    drive_key(K_ENTER, e1);
    idle(1);
  endtask

  task automatic test_borrar();
    logic e;
    logic exp_err;
    logic [3:0] exp_cnt;
    logic [31:0] exp_monto;
`ifdef INGRESO_MONTO_BORRAR_EN
    exp_err = 1'b0; exp_cnt = 4'd1; exp_monto = 32'd72;
`else
    exp_err = 1'b1; exp_cnt = 4'd2; exp_monto = 32'd782;
`endif
    drive_key(4'h7, e);
    drive_key(4'h8, e);
    drive_key(K_BORRAR, e);
    checks++;
    if (e !== exp_err || digitos_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL borrar_key: err=%b cnt=%0d expected %b %0d", e, digitos_cnt, exp_err, exp_cnt);
    end
    drive_key(4'h2, e);
    exp_q.push_back(exp_monto);
    drive_key(K_ENTER, e);
    idle(1);
  endtask

  task automatic test_habilitar_drop();
    logic e;
    drive_key(4'h4, e);
    drive_key(4'h5, e);
    @(negedge clk);
    habilitar = 1'b0; tecla = 4'h6; tecla_stb = 1'b1;
    @(negedge clk);
    tecla_stb = 1'b0;
    checks++;
    if (error_entrada !== 1'b0 || capturando !== 1'b0 || digitos_cnt !== 4'd0 || monto_stb !== 1'b0) begin
      errors++;
      $display("FAIL habilitar_drop: err=%b capt=%b cnt=%0d stb=%b expected 0 0 0 0",
               error_entrada, capturando, digitos_cnt, monto_stb);
    end
    habilitar = 1'b1;
    wait_capt();
    drive_key(4'h3, e);
    exp_q.push_back(32'd3);
    drive_key(K_ENTER, e);
    idle(1);
  endtask

  task automatic test_back_to_back();
    logic e;
    drive_key(4'h6, e);
    @(negedge clk);
    tecla = K_ENTER; tecla_stb = 1'b1;
    exp_q.push_back(32'd6);
    @(negedge clk);
    tecla = 4'h5;
    checks++;
    if (monto_stb !== 1'b1) begin
      errors++;
      $display("FAIL b2b_strobe: stb=%b expected 1", monto_stb);
    end
    @(negedge clk);
    tecla_stb = 1'b0;
    checks++;
    if (error_entrada !== 1'b0 || monto_stb !== 1'b0 || digitos_cnt !== 4'd0) begin
      errors++;
      $display("FAIL b2b_entrega_key: err=%b stb=%b cnt=%0d expected 0 0 0", error_entrada, monto_stb, digitos_cnt);
    end
    drive_key(K_ENTER, e);
    checks++;
    if (e !== 1'b1) begin
      errors++;
      $display("FAIL b2b_key_dropped: err=%b expected 1", e);
    end
  endtask

  task automatic test_reset_mid();
    logic e;
    drive_key(4'h5, e);
    drive_key(4'h5, e);
    checks++;
    if (digitos_cnt !== 4'd2) begin
      errors++;
      $display("FAIL reset_mid_pre: cnt=%0d expected 2", digitos_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({monto, monto_stb, digitos_cnt, error_entrada, capturando} !== 39'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: monto=%0d stb=%b cnt=%0d err=%b capt=%b expected all 0",
               monto, monto_stb, digitos_cnt, error_entrada, capturando);
    end
    wait_capt();
    drive_key(4'h8, e);
    checks++;
    if (digitos_cnt !== 4'd1) begin
      errors++;
      $display("FAIL reset_mid_resume: cnt=%0d expected 1", digitos_cnt);
    end
    exp_q.push_back(32'd8);
    drive_key(K_ENTER, e);
    idle(1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_empty_enter();
    test_invalid_cancel();
    test_borrar();
    test_habilitar_drop();
    test_back_to_back();
    test_reset_mid();
    idle(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_strobes: %0d deliveries pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
